// File: rtl/alu_pkg.sv
// Shared encodings for the ALU status stage: flag update commands,
// status-register bit positions and the reset value of P.
package alu_pkg;

  typedef enum logic [3:0] {
    FLG_NONE = 4'd0,
    FLG_NZ   = 4'd1,
    FLG_NZC  = 4'd2,
    FLG_NZCV = 4'd3,
    FLG_BIT  = 4'd4,
    FLG_PLP  = 4'd5,
    FLG_SEC  = 4'd6,
    FLG_CLC  = 4'd7,
    FLG_SEI  = 4'd8,
    FLG_CLI  = 4'd9,
    FLG_SED  = 4'd10,
    FLG_CLD  = 4'd11,
    FLG_CLV  = 4'd12,
    FLG_BRK  = 4'd13
  } flg_op_e;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  localparam logic [7:0] P_RST = 8'h34;

  // Bits 5 and 4 of P are not storage; they always read as one.
  function automatic logic [7:0] p_fix(input logic [7:0] p);
    return {p[7:6], 2'b11, p[3:0]};
  endfunction

endpackage

// File: rtl/alu_status_bcd_adjust.sv
// Nibble-wise decimal correction of a binary ALU byte. Each nibble is
// corrected independently; no carry propagates from low to high nibble.
module bcd_adjust (
  input  logic [7:0] value,
  input  logic       hc,
  input  logic       co,
  input  logic       sub,
  output logic [7:0] adjusted
);

  logic       lo_fix, hi_fix;
  logic [3:0] lo, hi;

  always_comb begin
    // Add corrects on carry out of a nibble, subtract on borrow (carry clear).
    lo_fix = sub ? ~hc : hc;
    hi_fix = sub ? ~co : co;
    lo     = value[3:0];
    hi     = value[7:4];
    if (lo_fix) lo = sub ? (value[3:0] - 4'd6) : (value[3:0] + 4'd6);
    if (hi_fix) hi = sub ? (value[7:4] - 4'd6) : (value[7:4] + 4'd6);
    adjusted = {hi, lo};
  end

endmodule

// File: rtl/alu_status.sv
// ALU result/status stage: optional decimal adjust of the ALU result and
// the P register. Decimal adjust is built only with ALU_STATUS_BCD_ADJ_EN.
module alu_status
  import alu_pkg::*;
#(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RDY,
  input  logic          alu_valid,
  input  logic [dw-1:0] alu_out,
  input  logic          alu_co,
  input  logic          alu_hc,
  input  logic          alu_v,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          sub,
  input  logic [3:0]    flag_op,
  input  logic [dw-1:0] bus_in,
  output logic [dw-1:0] result,
  output logic          result_valid,
  output logic [7:0]    P
);

  logic [dw-1:0] res_nxt;
  logic [7:0]    p_nxt;
  logic          n_nxt, z_nxt;

`ifdef ALU_STATUS_BCD_ADJ_EN
  logic [7:0] adj;

  bcd_adjust u_adj (
    .value    (alu_out[7:0]),
    .hc       (alu_hc),
    .co       (alu_co),
    .sub      (sub),
    .adjusted (adj)
  );

  logic unused_in;
  assign unused_in = ^{alu_n, bus_in};

  always_comb begin
    // D is sampled before the edge, so SED/CLD only affect later ops.
    res_nxt = alu_out;
    if (P[P_D]) res_nxt[7:0] = adj;
    n_nxt = res_nxt[dw-1];
    z_nxt = ~|res_nxt;
  end
`else
  logic unused_in;
  assign unused_in = ^{alu_hc, sub, bus_in};

  always_comb begin
    res_nxt = alu_out;
    n_nxt   = alu_n;
    z_nxt   = alu_z;
  end
`endif

  always_comb begin
    p_nxt = P;
    case (flag_op)
      FLG_NZ: if (alu_valid) begin
        p_nxt[P_N] = n_nxt;
        p_nxt[P_Z] = z_nxt;
      end
      FLG_NZC: if (alu_valid) begin
        p_nxt[P_N] = n_nxt;
        p_nxt[P_Z] = z_nxt;
        p_nxt[P_C] = alu_co;
      end
      FLG_NZCV: if (alu_valid) begin
        p_nxt[P_N] = n_nxt;
        p_nxt[P_Z] = z_nxt;
        p_nxt[P_C] = alu_co;
        p_nxt[P_V] = alu_v;
      end
      FLG_BIT: if (alu_valid) begin
        p_nxt[P_N] = bus_in[dw-1];
        p_nxt[P_V] = bus_in[dw-2];
        p_nxt[P_Z] = alu_z;
      end
      FLG_PLP: p_nxt = bus_in[7:0];
      FLG_SEC: p_nxt[P_C] = 1'b1;
      FLG_CLC: p_nxt[P_C] = 1'b0;
      FLG_SEI: p_nxt[P_I] = 1'b1;
      FLG_CLI: p_nxt[P_I] = 1'b0;
      FLG_SED: p_nxt[P_D] = 1'b1;
      FLG_CLD: p_nxt[P_D] = 1'b0;
      FLG_CLV: p_nxt[P_V] = 1'b0;
      FLG_BRK: p_nxt[P_I] = 1'b1;
      default: p_nxt = P;
    endcase
    p_nxt = p_fix(p_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      P            <= P_RST;
    end else if (RDY) begin
      result_valid <= alu_valid;
      if (alu_valid) result <= res_nxt;
      P <= p_nxt;
    end
  end

endmodule

// File: tb/tb_alu_status.sv
// Self-checking bench for alu_status: a reference model pushes expected
// outputs per cycle into a queue; they are popped and compared after the edge.
module tb_alu_status;
  import alu_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, RDY, alu_valid;
  logic [DW-1:0] alu_out, bus_in;
  logic          alu_co, alu_hc, alu_v, alu_z, alu_n, sub;
  logic [3:0]    flag_op;
  logic [DW-1:0] result;
  logic          result_valid;
  logic [7:0]    P;

  alu_status #(.dw(DW)) dut (
    .clk(clk), .reset(reset), .RDY(RDY), .alu_valid(alu_valid),
    .alu_out(alu_out), .alu_co(alu_co), .alu_hc(alu_hc), .alu_v(alu_v),
    .alu_z(alu_z), .alu_n(alu_n), .sub(sub), .flag_op(flag_op),
    .bus_in(bus_in), .result(result), .result_valid(result_valid), .P(P)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [DW-1:0] res;
    logic          rv;
    logic [7:0]    p;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_res;
  logic          m_rv;
  logic [7:0]    m_p;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_bcd(input logic [7:0] v, input logic hc,
                                       input logic co, input logic sb);
    logic [3:0] lo, hi;
    lo = v[3:0];
    hi = v[7:4];
    if (!sb && hc)  lo = lo + 4'd6;
    if (!sb && co)  hi = hi + 4'd6;
    if (sb && !hc)  lo = lo - 4'd6;
    if (sb && !co)  hi = hi - 4'd6;
    return {hi, lo};
  endfunction

  // Advance the reference model with the inputs currently driven.
  task automatic model_step();
    logic [DW-1:0] r;
    logic [7:0]    np;
    logic          n, z;
    if (reset) begin
      m_res = '0; m_rv = 1'b0; m_p = 8'h34;
    end else if (RDY) begin
      r = alu_out;
`ifdef ALU_STATUS_BCD_ADJ_EN
      if (m_p[3]) r[7:0] = m_bcd(alu_out[7:0], alu_hc, alu_co, sub);
      n = r[DW-1];
      z = (r == '0);
`else
      n = alu_n;
      z = alu_z;
`endif
      np = m_p;
      case (flag_op)
        4'd1:  if (alu_valid) begin np[7] = n; np[1] = z; end
        4'd2:  if (alu_valid) begin np[7] = n; np[1] = z; np[0] = alu_co; end
        4'd3:  if (alu_valid) begin np[7] = n; np[1] = z; np[0] = alu_co; np[6] = alu_v; end
        4'd4:  if (alu_valid) begin np[7] = bus_in[DW-1]; np[6] = bus_in[DW-2]; np[1] = alu_z; end
        4'd5:  np = bus_in[7:0];
        4'd6:  np[0] = 1'b1;
        4'd7:  np[0] = 1'b0;
        4'd8:  np[2] = 1'b1;
        4'd9:  np[2] = 1'b0;
        4'd10: np[3] = 1'b1;
        4'd11: np[3] = 1'b0;
        4'd12: np[6] = 1'b0;
        4'd13: np[2] = 1'b1;
        default: ;
      endcase
      np[5:4] = 2'b11;
      m_p  = np;
      m_rv = alu_valid;
      if (alu_valid) m_res = r;
    end
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    e.tag = tag; e.res = m_res; e.rv = m_rv; e.p = m_p;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_q"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({e.tag, "_res"}, 32'(result), 32'(e.res));
      chk({e.tag, "_rv"}, 32'(result_valid), 32'(e.rv));
      chk({e.tag, "_P"}, 32'(P), 32'(e.p));
    end
  endtask

  task automatic set(input logic rdy, input logic v, input logic [15:0] ao,
                     input logic co, input logic hc, input logic vv,
                     input logic [3:0] op, input logic [15:0] bus, input logic sb);
    reset = 1'b0; RDY = rdy; alu_valid = v; alu_out = ao;
    alu_co = co; alu_hc = hc; alu_v = vv; flag_op = op; bus_in = bus; sub = sb;
    alu_n = ao[15]; alu_z = (ao == 16'h0);
  endtask

  logic [15:0] exp_r;

  initial begin
    reset = 1'b1; RDY = 1'b0; alu_valid = 1'b0; alu_out = '0; bus_in = '0;
    alu_co = 0; alu_hc = 0; alu_v = 0; alu_z = 0; alu_n = 0; sub = 0; flag_op = 4'd0;
    m_res = 16'hDEAD; m_rv = 1'b1; m_p = 8'h00;
    cyc("rst0");
    cyc("rst1");

    // Decimal add/subtract vectors with D set.
    set(1, 0, 16'h0, 0, 0, 0, 4'd10, 16'h0, 0); cyc("sed");
    set(1, 1, 16'h001A, 0, 1, 0, 4'd2, 16'h0, 0); cyc("v035");
`ifdef ALU_STATUS_BCD_ADJ_EN
    exp_r = 16'h0010;
`else
    exp_r = 16'h001A;
`endif
    chk("v035_const", 32'(result), 32'(exp_r));
    chk("v035_C", 32'(P[0]), 32'd0);
    set(1, 1, 16'h00AA, 1, 1, 0, 4'd2, 16'h0, 0); cyc("v036");
    set(1, 1, 16'h000F, 1, 0, 0, 4'd2, 16'h0, 1); cyc("v037");
    chk("v037_C", 32'(P[0]), 32'd1);
    set(1, 1, 16'h1299, 0, 0, 0, 4'd1, 16'h0, 1); cyc("sub_both");

    // Binary NZCV, then RDY low holds everything.
    set(1, 0, 16'h0, 0, 0, 0, 4'd11, 16'h0, 0); cyc("cld");
    set(1, 1, 16'h8000, 0, 0, 1, 4'd3, 16'h0, 0); cyc("v038");
    chk("v038_N", 32'(P[7]), 32'd1);
    chk("v038_V", 32'(P[6]), 32'd1);
    set(0, 1, 16'h0001, 1, 1, 0, 4'd5, 16'h0000, 1); cyc("hold");
    chk("hold_res", 32'(result), 32'h8000);

    // PLP, then SED with a same-cycle op that must not be adjusted.
    set(1, 0, 16'h0, 0, 0, 0, 4'd5, 16'h00FF, 0); cyc("plp");
    chk("plp_const", 32'(P), 32'hFF);
    set(1, 0, 16'h0, 0, 0, 0, 4'd11, 16'h0, 0); cyc("cld2");
    set(1, 1, 16'h001A, 0, 1, 0, 4'd10, 16'h0, 0); cyc("sed_same");
    chk("sed_noadj", 32'(result), 32'h001A);
    set(1, 1, 16'h001A, 0, 1, 0, 4'd1, 16'h0, 0); cyc("sed_next");

    // BIT, invalid ALU ops ignored, unused encodings, set/clear ops.
    set(1, 1, 16'h0000, 0, 0, 0, 4'd4, 16'h4000, 0); cyc("bit");
    set(1, 0, 16'h8000, 1, 0, 1, 4'd3, 16'h0, 0); cyc("nzcv_inval");
    set(1, 1, 16'h0000, 1, 0, 1, 4'd14, 16'hFFFF, 0); cyc("op14");
    set(1, 0, 16'h0, 0, 0, 0, 4'd15, 16'hFFFF, 0); cyc("op15");
    for (int op = 6; op <= 13; op++) begin
      set(1, 0, 16'h0, 0, 0, 0, 4'(op), 16'h0, 0); cyc($sformatf("flg%0d", op));
    end

    // Reset while stalled mid-stream.
    set(1, 1, 16'h5555, 1, 1, 1, 4'd3, 16'h0, 0); cyc("pre_rst");
    set(0, 1, 16'h1234, 1, 1, 1, 4'd3, 16'h0, 0); reset = 1'b1; cyc("v040");
    chk("v040_P", 32'(P), 32'h34);
    set(1, 1, 16'h0042, 0, 0, 0, 4'd1, 16'h0, 0); cyc("post_rst");

    for (int i = 0; i < 300; i++) begin
      set($urandom_range(0, 7) != 0, $urandom_range(0, 1), 16'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 1));
      alu_z = $urandom_range(0, 1);
      alu_n = $urandom_range(0, 1);
      reset = ($urandom_range(0, 49) == 0);
      cyc("rnd");
    end

    chk("q_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_status.md
ALU_STATUS -- requirements
Module: alu_status

Interface
REQ-001 SHALL have parameter: dw, 16, data width (8 for 6502, 16 for 65Org16).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: RDY  input  1  stage enable; low holds all state.
REQ-005 SHALL have port: alu_valid  input  1  ALU outputs valid this cycle.
REQ-006 SHALL have port: alu_out  input  dw  registered ALU result (binary, pre-adjust).
REQ-007 SHALL have ports: alu_co, alu_hc, alu_v, alu_z, alu_n  input  1 each  registered ALU flags.
REQ-008 SHALL have port: sub  input  1  operation was subtract (selects BCD adjust direction).
REQ-009 SHALL have port: flag_op  input  4  flag update command (encodings in package).
REQ-010 SHALL have port: bus_in  input  dw  operand/stack data for BIT and PLP.
REQ-011 SHALL have port: result  output  dw  adjusted result, registered.
REQ-012 SHALL have port: result_valid  output  1  result holds a new value.
REQ-013 SHALL have port: P  output  8  status register {N,V,1,1,D,I,Z,C}.

Function
REQ-014 Latency SHALL be 1 cycle: alu_valid & RDY at edge k -> result, result_valid, P updated at edge k.
REQ-015 result_valid SHALL follow alu_valid each RDY cycle; RDY low holds result, result_valid, P.
REQ-016 Decimal adjust SHALL apply only when P.D=1, to bits [7:0] only; bits [dw-1:8] pass unchanged.
REQ-017 Add (sub=0): alu_hc=1 -> bits[3:0]+6 mod 16; alu_co=1 -> bits[7:4]+6 mod 16; no inter-nibble carry.
REQ-018 Subtract (sub=1): alu_hc=0 -> bits[3:0]-6 mod 16; alu_co=0 -> bits[7:4]-6 mod 16.
REQ-019 C SHALL load alu_co unmodified; V SHALL load alu_v unmodified.
REQ-020 N SHALL be result[dw-1]; Z SHALL be ~|result (post-adjust), for FLG_NZ/NZC/NZCV.
REQ-021 FLG_NONE: P unchanged; FLG_NZ: N,Z; FLG_NZC: N,Z,C; FLG_NZCV: N,Z,C,V.
REQ-022 ALU-sourced ops (NZ, NZC, NZCV, BIT) SHALL update P only when alu_valid=1; otherwise ignored.
REQ-023 FLG_BIT: N=bus_in[dw-1], V=bus_in[dw-2], Z=alu_z.
REQ-024 FLG_PLP: P[7:6], P[3:0] from bus_in[7:6], bus_in[3:0] regardless of alu_valid; P[5:4] read 1.
REQ-025 FLG_SEC/CLC/SEI/CLI/SED/CLD/CLV SHALL set/clear one bit regardless of alu_valid; FLG_BRK sets I.
REQ-026 D used for adjust SHALL be the pre-edge value; SED/CLD with alu_valid same cycle affects next op only.
REQ-027 Unused flag_op encodings SHALL behave as FLG_NONE.

Reset
REQ-028 reset SHALL win over RDY and all inputs.
REQ-029 Reset values: result=0, result_valid=0, P=8'h34 (I=1, D=0, others 0; bits 5,4 read 1).
REQ-030 Reset mid-operation SHALL discard the pending result; first post-reset alu_valid proceeds normally.

Configuration
REQ-031 Macro ALU_STATUS_BCD_ADJ_EN defined: REQ-016..018 in force.
REQ-032 Macro undefined: result=alu_out exactly, Z=alu_z, N=alu_n; D still stored and readable; no adjust logic.

Structure
REQ-033 Package alu_pkg SHALL hold flag_op encodings (FLG_*), P bit index constants, P reset constant 8'h34.
REQ-034 Combinational nibble adjust SHALL be sub-module bcd_adjust (in: value[7:0], hc, co, sub; out: adjusted[7:0]).

Verification
REQ-035 D=1, sub=0, alu_out=16'h001A, hc=1, co=0, NZC -> result=16'h0010, Z=0, C=0.
REQ-036 D=1, sub=0, alu_out=16'h00AA, hc=1, co=1, NZC -> result=16'h0000, Z=1, C=1, N=0.
REQ-037 D=1, sub=1, alu_out=16'h000F, hc=0, co=1, NZC -> result=16'h0009, C=1.
REQ-038 D=0, alu_out=16'h8000, NZCV with alu_v=1 -> result=16'h8000, N=1, V=1, Z=0; RDY=0 next cycle -> all held.
REQ-039 PLP with bus_in=16'h00FF -> P=8'hFF; SED with alu_valid and alu_out=16'h001A -> no adjust that cycle.
REQ-040 reset asserted with RDY=0 mid-stream -> result=0, result_valid=0, P=8'h34 next edge.
